writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
//  Producer side of the register file write port. Buffers results from execute/memory
//  (valid/ready in) and drains them in order, at most one per cycle, onto wr_en/wr_addr/wr_data.
//  Sits between the pipeline back-end and register_file. Optionally forwards queued,
//  not-yet-written values to the two read-address lookups.
// PARAMETERS
//  WIDTH          `WORD               data width of a register
//  ADDR_SPACE     `REG_ADDRESS_SPACE  register address width
//  DEPTH          `WB_QUEUE_DEPTH (4) queue entries; power of two, >=2
//  ZERO_REGISTER  5'b00000            hard-wired zero register; writes to it are discarded
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           reset, asynchronous, active-high
//  in_valid   in   1           result available from back-end
//  in_ready   out  1           queue can accept (count < DEPTH)
//  in_addr    in   ADDR_SPACE  destination register of result
//  in_data    in   WIDTH       result value
//  hold       in   1           write port unavailable this cycle; no drain
//  wr_en      out  1           to register_file write enable
//  wr_addr    out  ADDR_SPACE  to register_file write address (head entry)
//  wr_data    out  WIDTH       to register_file write data (head entry)
//  count      out  $clog2(DEPTH)+1  occupied entries
//  q1_addr    in   ADDR_SPACE  forward lookup 1 (tie to register_file r1_addr)
//  q2_addr    in   ADDR_SPACE  forward lookup 2 (tie to register_file r2_addr)
//  fwd1_hit   out  1           lookup 1 matches a queued entry
//  fwd1_data  out  WIDTH       youngest matching value for lookup 1
//  fwd2_hit   out  1           lookup 2 matches a queued entry
//  fwd2_data  out  WIDTH       youngest matching value for lookup 2
// BEHAVIOUR
//  - Storage: circular buffer, head/tail pointers wrap mod DEPTH, count register.
//  - Reset (async): head=tail=count=0, all valid bits cleared; wr_en=0, wr_addr=0, wr_data=0,
//    fwd*_hit=0, fwd*_data=0. in_ready=0 while rst high, 1 from first cycle after release.
//    Reset mid-operation discards every queued entry; none is written.
//  - Push: in_valid && in_ready at rising edge. in_addr==ZERO_REGISTER: handshake completes,
//    entry dropped, count unchanged.
//  - in_ready = (count < DEPTH), combinational from count only; no pass-through when full.
//  - Drain: wr_en = (count != 0) && !hold; wr_addr/wr_data = head entry (combinational, 0 when
//    empty). Pop at edge when wr_en. Strict FIFO order; register_file commits same edge.
//  - Latency: push at edge N -> wr_en high in cycle N..N+1 when empty and hold=0 -> committed edge N+1.
//  - Simultaneous push and pop: count unchanged; pop at count==DEPTH does not enable push same cycle.
//  - Empty queue: no bypass of in_* straight to wr_*; every result passes through storage.
//  - Hold: queue retains contents; pushes continue until full.
// CONFIGURATION
//  WB_QUEUE_FORWARD_EN defined: fwdN_hit=1 when qN_addr!=ZERO_REGISTER and a valid entry matches;
//    fwdN_data = youngest matching entry (closest to tail). Combinational, includes head entry
//    being written this cycle; excludes in_* not yet accepted.
//  Undefined: ports remain; fwd*_hit=0, fwd*_data=0; no match logic synthesised.
// STRUCTURE
//  specs.vh: `WORD, `REG_ADDRESS_SPACE, new `WB_QUEUE_DEPTH.
//  Sub-module wb_fwd_match: one lookup address vs entry array + valid mask -> hit + youngest
//    data (priority from tail backwards); instantiated twice under WB_QUEUE_FORWARD_EN.
// TESTING
//  1 push (5,32'hDEADBEEF), hold=0, empty -> next cycle wr_en=1, wr_addr=5, wr_data=DEADBEEF,
//    exactly one cycle; count back to 0.
//  2 hold=1, push 4 entries (1..4,data 10..40) -> count=4, in_ready=0; 5th in_valid stalls;
//    hold=0 -> writes 1,2,3,4 in order on consecutive cycles; 5th accepted cycle after first pop.
//  3 push (0,32'hFFFFFFFF) -> in_ready handshake, count stays 0, wr_en never asserts.
//  4 count=2 with hold=0, push every cycle -> count stays 2, write order equals push order.
//  5 FORWARD_EN, hold=1: push (3,1),(3,2),(7,9); q1_addr=3 -> fwd1_hit=1 fwd1_data=2;
//    q2_addr=0 -> fwd2_hit=0; macro off -> all fwd outputs 0.
//  6 3 entries queued, pulse rst mid-cycle -> outputs 0 immediately, count=0, no wr_en after release.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : writeback_queue_pkg
//  Purpose : Shared sizing constants and helpers for the write-back queue.
//  Revision: 1.0 - initial release
// ============================================================================
package writeback_queue_pkg;

    localparam int WORD              = 32;  // data width of a register
    localparam int REG_ADDRESS_SPACE = 5;   // register address width
    localparam int WB_QUEUE_DEPTH    = 4;   // queue entries, power of two

    // Pointer width for a circular buffer of the given depth.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module  : wb_fwd_match
//  Purpose : Compares one lookup address against every queued entry and
//            returns a hit flag plus the data of the youngest valid match.
//  Revision: 1.0 - initial release
// ============================================================================
module wb_fwd_match
    import writeback_queue_pkg::*;
#(
    parameter int                    WIDTH         = WORD,
    parameter int                    ADDR_SPACE    = REG_ADDRESS_SPACE,
    parameter int                    DEPTH         = WB_QUEUE_DEPTH,
    parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = '0
)(
    input  logic [ADDR_SPACE-1:0]             lookup_addr_i,
    input  logic [DEPTH-1:0][ADDR_SPACE-1:0]  entry_addr_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]       entry_data_i,
    input  logic [DEPTH-1:0]                  valid_i,
    input  logic [ptr_bits(DEPTH)-1:0]        tail_i,
    output logic                              hit_o,
    output logic [WIDTH-1:0]                  data_o
);

    localparam int PTR_W = ptr_bits(DEPTH);

    logic [PTR_W-1:0] w_idx;

    // Walk from the oldest slot to the youngest so the last match (closest to tail) wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        w_idx  = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            w_idx = tail_i - PTR_W'(i);
            if (valid_i[w_idx] && (entry_addr_i[w_idx] == lookup_addr_i) &&
                (lookup_addr_i != ZERO_REGISTER)) begin
                hit_o  = 1'b1;
                data_o = entry_data_i[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module  : writeback_queue
//  Purpose : In-order buffer between the pipeline back-end and the register
//            file write port. Accepts results via valid/ready and drains at
//            most one per cycle. Writes to the zero register are dropped.
//  Config  : WB_QUEUE_FORWARD_EN - when defined, queued values are forwarded
//            to the two read-address lookups; otherwise fwd outputs are 0.
//  Revision: 1.0 - initial release
// ============================================================================
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int                    WIDTH         = WORD,
    parameter int                    ADDR_SPACE    = REG_ADDRESS_SPACE,
    parameter int                    DEPTH         = WB_QUEUE_DEPTH,
    parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = '0
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_SPACE-1:0]    in_addr,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     hold,
    output logic                     wr_en,
    output logic [ADDR_SPACE-1:0]    wr_addr,
    output logic [WIDTH-1:0]         wr_data,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [ADDR_SPACE-1:0]    q1_addr,
    input  logic [ADDR_SPACE-1:0]    q2_addr,
    output logic                     fwd1_hit,
    output logic [WIDTH-1:0]         fwd1_data,
    output logic                     fwd2_hit,
    output logic [WIDTH-1:0]         fwd2_data
);

    localparam int               PTR_W   = ptr_bits(DEPTH);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0]                 head_q, head_d;
    logic [PTR_W-1:0]                 tail_q, tail_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_SPACE-1:0] addr_q;
    logic [DEPTH-1:0][WIDTH-1:0]      data_q;

    logic w_empty;
    logic w_push_acc;
    logic w_push_store;
    logic w_pop;

    // Handshake and drain decisions; ready depends only on occupancy (and reset).
    assign w_empty      = (count_q == '0);
    assign in_ready     = !rst && (count_q < DEPTH_C);
    assign w_push_acc   = in_valid && in_ready;
    assign w_push_store = w_push_acc && (in_addr != ZERO_REGISTER);
    assign w_pop        = wr_en;

    assign wr_en   = !w_empty && !hold;
    assign wr_addr = w_empty ? '0 : addr_q[head_q];
    assign wr_data = w_empty ? '0 : data_q[head_q];
    assign count   = count_q;

    // Next-state pointers, occupancy and valid mask for push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (w_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (w_push_store) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({w_push_store, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards every queued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry storage written at the tail on an accepted, non-discarded push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (w_push_store) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end

`ifdef WB_QUEUE_FORWARD_EN
    wb_fwd_match #(
        .WIDTH         (WIDTH),
        .ADDR_SPACE    (ADDR_SPACE),
        .DEPTH         (DEPTH),
        .ZERO_REGISTER (ZERO_REGISTER)
    ) u_fwd1 (
        .lookup_addr_i (q1_addr),
        .entry_addr_i  (addr_q),
        .entry_data_i  (data_q),
        .valid_i       (valid_q),
        .tail_i        (tail_q),
        .hit_o         (fwd1_hit),
        .data_o        (fwd1_data)
    );

    wb_fwd_match #(
        .WIDTH         (WIDTH),
        .ADDR_SPACE    (ADDR_SPACE),
        .DEPTH         (DEPTH),
        .ZERO_REGISTER (ZERO_REGISTER)
    ) u_fwd2 (
        .lookup_addr_i (q2_addr),
        .entry_addr_i  (addr_q),
        .entry_data_i  (data_q),
        .valid_i       (valid_q),
        .tail_i        (tail_q),
        .hit_o         (fwd2_hit),
        .data_o        (fwd2_data)
    );
`else
    // Forwarding disabled: lookup addresses are accepted but ignored.
    logic w_unused_lookup;
    assign w_unused_lookup = ^{q1_addr, q2_addr};
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module  : tb_writeback_queue
//  Purpose : Self-checking bench for writeback_queue: vector table for the
//            single-cycle behaviour plus directed multi-cycle sequences.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        hold;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  count;
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_queue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .hold      (hold),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .count     (count),
        .q1_addr   (q1_addr),
        .q2_addr   (q2_addr),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        h;
        logic        rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [31:0] d,
                                input logic h, input logic rdy, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [2:0] cnt);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.h = h;
        r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd; r.cnt = cnt;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd,
                              input logic [2:0] cnt);
        cmp({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        cmp({tag, ".wr_en"},    32'(wr_en),    32'(we));
        cmp({tag, ".wr_addr"},  32'(wr_addr),  32'(wa));
        cmp({tag, ".wr_data"},  wr_data,       wd);
        cmp({tag, ".count"},    32'(count),    32'(cnt));
    endtask

    task automatic check_fwd(input string tag, input logic h1, input logic [31:0] d1,
                             input logic h2, input logic [31:0] d2);
        cmp({tag, ".fwd1_hit"},  32'(fwd1_hit), 32'(h1));
        cmp({tag, ".fwd1_data"}, fwd1_data,     d1);
        cmp({tag, ".fwd2_hit"},  32'(fwd2_hit), 32'(h2));
        cmp({tag, ".fwd2_data"}, fwd2_data,     d2);
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic h);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        hold     = h;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Single-cycle vectors: applied just after an edge, checked before the next one
        vecs[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0);
        vecs[1]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 3'd1);
        vecs[2]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0);
        vecs[3]  = mk(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0);
        vecs[4]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0);
        vecs[5]  = mk(1'b1, 5'd1, 32'd100,      1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0);
        vecs[6]  = mk(1'b1, 5'd2, 32'd200,      1'b1, 1'b1, 1'b0, 5'd1, 32'd100,      3'd1);
        vecs[7]  = mk(1'b1, 5'd3, 32'd300,      1'b0, 1'b1, 1'b1, 5'd1, 32'd100,      3'd2);
        vecs[8]  = mk(1'b1, 5'd4, 32'd400,      1'b0, 1'b1, 1'b1, 5'd2, 32'd200,      3'd2);
        vecs[9]  = mk(1'b1, 5'd5, 32'd500,      1'b0, 1'b1, 1'b1, 5'd3, 32'd300,      3'd2);
        vecs[10] = mk(1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd4, 32'd400,      3'd2);
        vecs[11] = mk(1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd5, 32'd500,      3'd1);
        vecs[12] = mk(1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0);

        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        q1_addr = 5'd0;
        q2_addr = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 5'd0, 32'h0, 3'd0);
        check_fwd("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_outs("post_reset", 1'b1, 1'b0, 5'd0, 32'h0, 3'd0);

        // Single push, zero-register drop, steady push+pop at count 2
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].h);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we,
                       vecs[i].wa, vecs[i].wd, vecs[i].cnt);
        end

        // Fill under hold, stall the fifth push, then drain in order
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive(1'b1, 5'(k), 32'(k * 10), 1'b1);
            @(negedge clk);
            check_outs($sformatf("fill%0d", k), 1'b1, 1'b0,
                       (k == 1) ? 5'd0 : 5'd1, (k == 1) ? 32'd0 : 32'd10, 3'(k - 1));
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            drive(1'b1, 5'd9, 32'd99, 1'b1);
            @(negedge clk);
            check_outs($sformatf("full_stall%0d", k), 1'b0, 1'b0, 5'd1, 32'd10, 3'd4);
        end
        next_cycle();
        drive(1'b1, 5'd9, 32'd99, 1'b0);
        @(negedge clk);
        check_outs("drain1", 1'b0, 1'b1, 5'd1, 32'd10, 3'd4);
        next_cycle();
        @(negedge clk);
        check_outs("drain2", 1'b1, 1'b1, 5'd2, 32'd20, 3'd3);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        check_outs("drain3", 1'b1, 1'b1, 5'd3, 32'd30, 3'd3);
        next_cycle();
        @(negedge clk);
        check_outs("drain4", 1'b1, 1'b1, 5'd4, 32'd40, 3'd2);
        next_cycle();
        @(negedge clk);
        check_outs("drain5", 1'b1, 1'b1, 5'd9, 32'd99, 3'd1);
        next_cycle();
        @(negedge clk);
        check_outs("drained", 1'b1, 1'b0, 5'd0, 32'h0, 3'd0);

        // Forwarding lookups with duplicate destinations held in the queue
        next_cycle(); drive(1'b1, 5'd3, 32'd1, 1'b1);
        next_cycle(); drive(1'b1, 5'd3, 32'd2, 1'b1);
        next_cycle(); drive(1'b1, 5'd7, 32'd9, 1'b1);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b1);
        q1_addr = 5'd3;
        q2_addr = 5'd0;
        @(negedge clk);
        check_outs("fwd_q", 1'b1, 1'b0, 5'd3, 32'd1, 3'd3);
`ifdef WB_QUEUE_FORWARD_EN
        check_fwd("fwd_a", 1'b1, 32'd2, 1'b0, 32'h0);
`else
        check_fwd("fwd_a", 1'b0, 32'h0, 1'b0, 32'h0);
`endif
        #1;
        q2_addr = 5'd7;
        #1;
`ifdef WB_QUEUE_FORWARD_EN
        check_fwd("fwd_b", 1'b1, 32'd2, 1'b1, 32'd9);
`else
        check_fwd("fwd_b", 1'b0, 32'h0, 1'b0, 32'h0);
`endif

        // Mid-cycle reset with three entries queued and the write port free
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        check_outs("pre_rst", 1'b1, 1'b1, 5'd3, 32'd1, 3'd3);
        #1;
        rst = 1'b1;
        #1;
        check_outs("mid_rst", 1'b0, 1'b0, 5'd0, 32'h0, 3'd0);
        check_fwd("mid_rst", 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_outs($sformatf("after_rst%0d", k), 1'b1, 1'b0, 5'd0, 32'h0, 3'd0);
            check_fwd($sformatf("after_rst%0d", k), 1'b0, 32'h0, 1'b0, 32'h0);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
